native_bus_endpoint: RTL and testbench

Memory-mapped byte-register endpoint on the native parallel bus. It owns RANGE registers starting at BASE_ADDR and accepts single-cycle writes. It returns read data only for addresses inside its window and drives zero otherwise. This lets the rdata outputs of several endpoints be OR-combined into one host rdata bus. Several instances with disjoint windows share r_wn, addr and wdata from one bus host.

---
 rtl/native_bus_endpoint.sv | 71 +++++++
 tb/tb_native_bus_endpoint.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/native_bus_endpoint.sv
// rtl/native_bus_endpoint.sv - byte-register endpoint on the native parallel bus, OR-combinable read data
module native_bus_endpoint #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int BASE_ADDR  = 0,
  parameter int RANGE      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  r_wn,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  // One extra address bit so BASE_ADDR+RANGE = 2**ADDR_WIDTH is representable.
  localparam int AW1   = ADDR_WIDTH + 1;
  localparam int IDX_W = (RANGE > 1) ? $clog2(RANGE) : 1;
  localparam logic [AW1-1:0] BASE_EXT  = AW1'(BASE_ADDR);
  localparam logic [AW1-1:0] RANGE_EXT = AW1'(RANGE);

  if (RANGE < 1 || BASE_ADDR < 0 ||
      (longint'(BASE_ADDR) + longint'(RANGE)) > (longint'(1) << ADDR_WIDTH)) begin : g_param_check
    $error("native_bus_endpoint: window BASE_ADDR=%0d RANGE=%0d does not fit ADDR_WIDTH=%0d",
           BASE_ADDR, RANGE, ADDR_WIDTH);
  end

  logic [DATA_WIDTH-1:0] regs_q [RANGE];
  logic [DATA_WIDTH-1:0] regs_d [RANGE];
  logic [AW1-1:0]        off_ext;
  logic [IDX_W-1:0]      idx;
  logic                  hit;
  logic [DATA_WIDTH-1:0] rd_word;

  // Window decode: an address below BASE_ADDR wraps to >= 2**ADDR_WIDTH >= RANGE,
  // so one unsigned compare of the offset covers both bounds.
  always_comb begin
    off_ext = {1'b0, addr} - BASE_EXT;
    hit     = (off_ext < RANGE_EXT);
    idx     = off_ext[IDX_W-1:0];
  end

  // Next register state: a write cycle that hits the window updates one register.
  always_comb begin
    regs_d = regs_q;
    if (!r_wn && hit) begin
      regs_d[idx] = wdata;
    end
  end

  // Register storage; reset wins over a simultaneous write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < RANGE; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read path: zero unless this endpoint is addressed for a read outside reset.
  always_comb begin
    rd_word = '0;
    if (hit) begin
      rd_word = regs_q[idx];
    end
    rdata = (rst_n && r_wn && hit) ? rd_word : '0;
  end

endmodule

// File: tb/tb_native_bus_endpoint.sv
// tb/tb_native_bus_endpoint.sv - self-checking bench: three endpoints sharing one bus, OR-combined rdata
module tb_native_bus_endpoint;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       r_wn;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata0, rdata1, rdata2;
  logic [7:0] rdata_or;

  int compared   = 0;
  int mismatched = 0;

  // Reference memory indexed by absolute bus address.
  logic [7:0] model [256];

  always #5 clk = ~clk;

  assign rdata_or = rdata0 | rdata1 | rdata2;

  native_bus_endpoint #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .BASE_ADDR(0), .RANGE(8)) u_ep0 (
    .clk(clk), .rst_n(rst_n), .r_wn(r_wn), .addr(addr), .wdata(wdata), .rdata(rdata0));

  native_bus_endpoint #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .BASE_ADDR(32), .RANGE(128)) u_ep1 (
    .clk(clk), .rst_n(rst_n), .r_wn(r_wn), .addr(addr), .wdata(wdata), .rdata(rdata1));

  native_bus_endpoint #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .BASE_ADDR(248), .RANGE(8)) u_ep2 (
    .clk(clk), .rst_n(rst_n), .r_wn(r_wn), .addr(addr), .wdata(wdata), .rdata(rdata2));

  function automatic bit in_win(input int ep, input int a);
    case (ep)
      0:       return (a >= 0)   && (a < 8);
      1:       return (a >= 32)  && (a < 160);
      default: return (a >= 248) && (a < 256);
    endcase
  endfunction

  function automatic bit owned(input int a);
    return in_win(0, a) || in_win(1, a) || in_win(2, a);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive just after the rising edge, check at the falling edge,
  // then let the next rising edge commit.
  task automatic cycle(input logic rn, input logic w_n, input int a, input logic [7:0] d,
                       input string tag);
    logic [7:0] e0, e1, e2;
    bit         rd;
    rst_n = rn;
    r_wn  = w_n;
    addr  = 8'(a);
    wdata = d;
    @(negedge clk);
    rd = rn && w_n;
    e0 = (rd && in_win(0, a)) ? model[a] : 8'h00;
    e1 = (rd && in_win(1, a)) ? model[a] : 8'h00;
    e2 = (rd && in_win(2, a)) ? model[a] : 8'h00;
    check({tag, "/ep0"}, rdata0, e0);
    check({tag, "/ep1"}, rdata1, e1);
    check({tag, "/ep2"}, rdata2, e2);
    check({tag, "/or"},  rdata_or, e0 | e1 | e2);
    if (!rn) begin
      for (int i = 0; i < 256; i++) model[i] = 8'h00;
    end else if (!w_n && owned(a)) begin
      model[a] = d;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [7:0] d, input string tag);
    cycle(1'b1, 1'b0, a, d, tag);
  endtask

  task automatic rd(input int a, input string tag);
    cycle(1'b1, 1'b1, a, 8'h00, tag);
  endtask

  initial begin
    rst_n = 1'b0;
    r_wn  = 1'b1;
    addr  = 8'h00;
    wdata = 8'h00;
    for (int i = 0; i < 256; i++) model[i] = 8'hxx;
    @(posedge clk);
    #1;

    // Reset held two cycles, rdata must be 0 even when addressed.
    cycle(1'b0, 1'b1, 3, 8'h00, "reset_hold0");
    cycle(1'b0, 1'b1, 40, 8'h00, "reset_hold1");
    for (int a = 0; a < 8; a++) rd(a, "reset_clear");

    // Write/readback; a write cycle shows 0 on rdata, the next read shows the data.
    wr(3, 8'hA5, "wr3");
    rd(3, "rb3_next");
    check("rb3_const", rdata_or, 8'hA5);
    wr(7, 8'h5A, "wr7");
    for (int a = 0; a < 8; a++) rd(a, "readback");
    check("rb7_const", rdata_or, 8'h5A);

    // Window bounds of the 32..159 endpoint.
    wr(32, 8'h11, "wr32");
    wr(159, 8'h22, "wr159");
    wr(31, 8'h33, "wr31_miss");
    wr(160, 8'h44, "wr160_miss");
    rd(32, "rd32");
    check("rd32_const", rdata1, 8'h11);
    rd(159, "rd159");
    check("rd159_const", rdata1, 8'h22);
    rd(31, "rd31");
    check("rd31_const", rdata_or, 8'h00);
    rd(160, "rd160");
    check("rd160_const", rdata_or, 8'h00);
    rd(33, "rd33_unchanged");
    rd(158, "rd158_unchanged");

    // OR-combined endpoints.
    wr(5, 8'hFF, "wr5");
    wr(40, 8'h0F, "wr40");
    rd(5, "or5");
    check("or5_const", rdata_or, 8'hFF);
    rd(40, "or40");
    check("or40_const", rdata_or, 8'h0F);
    rd(20, "or20");
    check("or20_const", rdata_or, 8'h00);

    // Back-to-back writes to one offset: last wins.
    wr(6, 8'h01, "b2b_a");
    wr(6, 8'h02, "b2b_b");
    rd(6, "b2b_rd");
    check("b2b_const", rdata_or, 8'h02);

    // Window ending at the top of the address space.
    wr(255, 8'hC3, "wr255");
    wr(248, 8'h3C, "wr248");
    wr(247, 8'h99, "wr247_miss");
    rd(255, "rd255");
    check("rd255_const", rdata2, 8'hC3);
    rd(248, "rd248");
    rd(247, "rd247");
    check("rd247_const", rdata_or, 8'h00);

    // Randomized traffic, biased toward window edges.
    for (int n = 0; n < 400; n++) begin
      int a;
      logic wn;
      case ($urandom_range(0, 3))
        0:       a = int'($urandom_range(0, 255));
        1:       a = int'($urandom_range(0, 9));
        2:       a = int'($urandom_range(30, 34)) + (($urandom_range(0, 1) == 1) ? 127 : 0);
        default: a = int'($urandom_range(246, 255));
      endcase
      wn = ($urandom_range(0, 2) != 0);
      cycle(1'b1, wn, a, 8'($urandom), "random");
    end

    // Reset mid-operation together with a write: everything lost.
    wr(2, 8'h77, "mid_wr");
    rd(2, "mid_rd_before");
    check("mid_before_const", rdata_or, 8'h77);
    cycle(1'b0, 1'b0, 2, 8'h99, "mid_reset_wr");
    rd(2, "mid_rd_after");
    check("mid_after_const", rdata_or, 8'h00);
    rd(40, "mid_rd40_after");
    rd(255, "mid_rd255_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
